lsu_mem_sequencer: RTL and testbench

- Sequences one load/store at a time between the execute stage and the data-memory bus.
- Accepts an LSU request (opcode, byte address, store data) via valid/ready.
- Checks alignment, issues a word-aligned request with byte enables and lane-replicated write data, waits for grant and response, then returns lane-extracted, sign/zero-extended load data with a one-cycle done pulse.
- Sits between the execute unit and the data-memory port; the pipeline stalls while lsu_ready_o is low.

---
 rtl/lsu_mem_sequencer.sv | 278 +++++++++++++++++++++++++++
 tb/tb_lsu_mem_sequencer.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_mem_sequencer.sv
// Single-outstanding load/store sequencer between the execute stage and a
// grant/rvalid data-memory port, with alignment checks and a bus timeout.
`timescale 1ns/1ps

`ifndef API_DATA_WIDTH
`define API_DATA_WIDTH 32
`endif
`ifndef API_ADDR_WIDTH
`define API_ADDR_WIDTH 32
`endif
`ifndef LSU_OPCODE_WIDTH
`define LSU_OPCODE_WIDTH 4
`endif
`ifndef LSU_OPCODE_LB
`define LSU_OPCODE_LB  4'h0
`define LSU_OPCODE_LH  4'h1
`define LSU_OPCODE_LW  4'h2
`define LSU_OPCODE_LBU 4'h4
`define LSU_OPCODE_LHU 4'h5
`define LSU_OPCODE_SB  4'h8
`define LSU_OPCODE_SH  4'h9
`define LSU_OPCODE_SW  4'hA
`endif

module lsu_mem_sequencer #(
  parameter int DATA_W         = `API_DATA_WIDTH,
  parameter int ADDR_W         = `API_ADDR_WIDTH,
  parameter int OPC_W          = `LSU_OPCODE_WIDTH,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              lsu_valid_i,
  output logic              lsu_ready_o,
  input  logic [OPC_W-1:0]  lsu_opcode_i,
  input  logic [ADDR_W-1:0] lsu_addr_i,
  input  logic [DATA_W-1:0] lsu_wdata_i,
  output logic              lsu_done_o,
  output logic [DATA_W-1:0] lsu_rdata_o,
  output logic              lsu_err_o,
  output logic [1:0]        lsu_err_code_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [3:0]        mem_be_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic              mem_gnt_i,
  input  logic              mem_rvalid_i,
  input  logic [DATA_W-1:0] mem_rdata_i
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_REQ  = 3'd1,
    ST_WAIT = 3'd2,
    ST_DONE = 3'd3,
    ST_ERR  = 3'd4
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [OPC_W-1:0]   opc_q, opc_d;
  logic [1:0]         off_q, off_d;
  logic               ready_q, ready_d;
  logic               req_q, req_d;
  logic               we_q, we_d;
  logic [3:0]         be_q, be_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [DATA_W-1:0]  wdata_q, wdata_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic [1:0]         code_q, code_d;
  logic [DATA_W-1:0]  rdata_q, rdata_d;

  logic               dec_legal_s, dec_store_s, dec_misal_s;
  logic [1:0]         dec_size_s;
  logic [3:0]         dec_be_s;
  logic [DATA_W-1:0]  dec_wdata_s;
  logic [7:0]         ld_byte_s;
  logic [15:0]        ld_half_s;
  logic [DATA_W-1:0]  ld_res_s;
  logic [CNT_W-1:0]   cnt_inc_s;
  logic               to_hit_s;
  logic               clr_bus_s;

  // Request decode: access size (0 byte, 1 half, 2 word), legality, lanes.
  always_comb begin
    dec_legal_s = 1'b1;
    dec_store_s = 1'b0;
    dec_size_s  = 2'd0;
    case (lsu_opcode_i)
      `LSU_OPCODE_LB, `LSU_OPCODE_LBU: dec_size_s = 2'd0;
      `LSU_OPCODE_LH, `LSU_OPCODE_LHU: dec_size_s = 2'd1;
      `LSU_OPCODE_LW:                  dec_size_s = 2'd2;
      `LSU_OPCODE_SB: begin dec_size_s = 2'd0; dec_store_s = 1'b1; end
      `LSU_OPCODE_SH: begin dec_size_s = 2'd1; dec_store_s = 1'b1; end
      `LSU_OPCODE_SW: begin dec_size_s = 2'd2; dec_store_s = 1'b1; end
      default:        dec_legal_s = 1'b0;
    endcase
    case (dec_size_s)
      2'd0: begin
        dec_misal_s = 1'b0;
        dec_be_s    = 4'b0001 << lsu_addr_i[1:0];
        dec_wdata_s = {4{lsu_wdata_i[7:0]}};
      end
      2'd1: begin
        dec_misal_s = lsu_addr_i[0];
        dec_be_s    = 4'b0011 << lsu_addr_i[1:0];
        dec_wdata_s = {2{lsu_wdata_i[15:0]}};
      end
      default: begin
        dec_misal_s = |lsu_addr_i[1:0];
        dec_be_s    = 4'b1111;
        dec_wdata_s = lsu_wdata_i;
      end
    endcase
  end

  // Load result: pick the addressed lane of the read word and extend it.
  always_comb begin
    ld_byte_s = mem_rdata_i[{off_q, 3'b000} +: 8];
    ld_half_s = off_q[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];
    case (opc_q)
      `LSU_OPCODE_LB:  ld_res_s = {{24{ld_byte_s[7]}}, ld_byte_s};
      `LSU_OPCODE_LBU: ld_res_s = {24'h000000, ld_byte_s};
      `LSU_OPCODE_LH:  ld_res_s = {{16{ld_half_s[15]}}, ld_half_s};
      `LSU_OPCODE_LHU: ld_res_s = {16'h0000, ld_half_s};
      `LSU_OPCODE_LW:  ld_res_s = mem_rdata_i;
      default:         ld_res_s = 32'h0000_0000;
    endcase
  end

  assign cnt_inc_s = cnt_q + CNT_W'(1);
  assign to_hit_s  = (TIMEOUT_CYCLES != 0) && (cnt_inc_s == CNT_LIMIT);

  // Next-state and next-output logic.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    opc_d     = opc_q;
    off_d     = off_q;
    ready_d   = ready_q;
    req_d     = req_q;
    we_d      = we_q;
    be_d      = be_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    code_d    = 2'b00;
    rdata_d   = rdata_q;
    clr_bus_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (lsu_valid_i && ready_q) begin
          opc_d   = lsu_opcode_i;
          off_d   = lsu_addr_i[1:0];
          cnt_d   = '0;
          ready_d = 1'b0;
          if (!dec_legal_s) begin
            state_d = ST_ERR;
            err_d   = 1'b1;
            code_d  = 2'b11;
          end else if (dec_misal_s) begin
            state_d = ST_ERR;
            err_d   = 1'b1;
            code_d  = 2'b01;
          end else begin
            state_d = ST_REQ;
            req_d   = 1'b1;
            we_d    = dec_store_s;
            be_d    = dec_be_s;
            addr_d  = {lsu_addr_i[ADDR_W-1:2], 2'b00};
            wdata_d = dec_store_s ? dec_wdata_s : '0;
          end
        end else begin
          ready_d = 1'b1;
        end
      end
      ST_REQ: begin
        cnt_d = cnt_inc_s;
        if (mem_gnt_i) begin
          state_d   = ST_WAIT;
          clr_bus_s = 1'b1;
        end else if (to_hit_s) begin
          state_d   = ST_ERR;
          err_d     = 1'b1;
          code_d    = 2'b10;
          clr_bus_s = 1'b1;
        end else begin
          state_d = ST_REQ;
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_inc_s;
        if (mem_rvalid_i) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
          rdata_d = ld_res_s;
        end else if (to_hit_s) begin
          state_d = ST_ERR;
          err_d   = 1'b1;
          code_d  = 2'b10;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_DONE, ST_ERR: begin
        state_d = ST_IDLE;
        ready_d = 1'b1;
      end
      default: begin
        state_d   = ST_IDLE;
        ready_d   = 1'b1;
        clr_bus_s = 1'b1;
      end
    endcase
    if (clr_bus_s) begin
      req_d   = 1'b0;
      we_d    = 1'b0;
      be_d    = 4'b0000;
      addr_d  = '0;
      wdata_d = '0;
    end else begin
      req_d = req_d;
    end
  end

  // State and registered outputs; reset takes effect without a clock edge.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      opc_q   <= '0;
      off_q   <= 2'b00;
      ready_q <= 1'b1;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      be_q    <= 4'b0000;
      addr_q  <= '0;
      wdata_q <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      code_q  <= 2'b00;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      opc_q   <= opc_d;
      off_q   <= off_d;
      ready_q <= ready_d;
      req_q   <= req_d;
      we_q    <= we_d;
      be_q    <= be_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      done_q  <= done_d;
      err_q   <= err_d;
      code_q  <= code_d;
      rdata_q <= rdata_d;
    end
  end

  assign lsu_ready_o    = ready_q;
  assign lsu_done_o     = done_q;
  assign lsu_rdata_o    = rdata_q;
  assign lsu_err_o      = err_q;
  assign lsu_err_code_o = code_q;
  assign mem_req_o      = req_q;
  assign mem_we_o       = we_q;
  assign mem_be_o       = be_q;
  assign mem_addr_o     = addr_q;
  assign mem_wdata_o    = wdata_q;

endmodule

// File: tb/tb_lsu_mem_sequencer.sv
// Bench for lsu_mem_sequencer: directed cases plus random transactions checked
// against a size/lane arithmetic reference model.
`timescale 1ns/1ps

`ifndef LSU_OPCODE_LB
`define LSU_OPCODE_LB  4'h0
`define LSU_OPCODE_LH  4'h1
`define LSU_OPCODE_LW  4'h2
`define LSU_OPCODE_LBU 4'h4
`define LSU_OPCODE_LHU 4'h5
`define LSU_OPCODE_SB  4'h8
`define LSU_OPCODE_SH  4'h9
`define LSU_OPCODE_SW  4'hA
`endif

module tb_lsu_mem_sequencer;

  logic        clk, rst;
  logic        valid, ready, done, err, req, we, gnt, rvalid;
  logic [3:0]  opc, be;
  logic [31:0] addr, wdata, rdata_o, maddr, mwdata, mrdata;
  logic [1:0]  code;
  logic        valid2, ready2, done2, err2, req2, we2, gnt2, rvalid2;
  logic [3:0]  opc2, be2;
  logic [31:0] addr2, wdata2, rdata2_o, maddr2, mwdata2, mrdata2;
  logic [1:0]  code2;

  int          total = 0;
  int          bad = 0;
  logic [31:0] exp_rdata = 32'h0;
  logic [3:0]  rop;

  lsu_mem_sequencer u_dut (
    .clk_i(clk), .rst_i(rst),
    .lsu_valid_i(valid), .lsu_ready_o(ready), .lsu_opcode_i(opc),
    .lsu_addr_i(addr), .lsu_wdata_i(wdata), .lsu_done_o(done),
    .lsu_rdata_o(rdata_o), .lsu_err_o(err), .lsu_err_code_o(code),
    .mem_req_o(req), .mem_we_o(we), .mem_be_o(be), .mem_addr_o(maddr),
    .mem_wdata_o(mwdata), .mem_gnt_i(gnt), .mem_rvalid_i(rvalid),
    .mem_rdata_i(mrdata)
  );

  lsu_mem_sequencer #(.TIMEOUT_CYCLES(4)) u_dut_to (
    .clk_i(clk), .rst_i(rst),
    .lsu_valid_i(valid2), .lsu_ready_o(ready2), .lsu_opcode_i(opc2),
    .lsu_addr_i(addr2), .lsu_wdata_i(wdata2), .lsu_done_o(done2),
    .lsu_rdata_o(rdata2_o), .lsu_err_o(err2), .lsu_err_code_o(code2),
    .mem_req_o(req2), .mem_we_o(we2), .mem_be_o(be2), .mem_addr_o(maddr2),
    .mem_wdata_o(mwdata2), .mem_gnt_i(gnt2), .mem_rvalid_i(rvalid2),
    .mem_rdata_i(mrdata2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference decode: access size in bytes, legality, direction, signedness.
  function automatic void ref_decode(input logic [3:0] op, output int size,
                                     output bit legal, output bit store, output bit sgn);
    legal = 1'b1; store = 1'b0; sgn = 1'b0; size = 1;
    case (op)
      `LSU_OPCODE_LB:  begin size = 1; sgn = 1'b1; end
      `LSU_OPCODE_LBU: size = 1;
      `LSU_OPCODE_LH:  begin size = 2; sgn = 1'b1; end
      `LSU_OPCODE_LHU: size = 2;
      `LSU_OPCODE_LW:  size = 4;
      `LSU_OPCODE_SB:  begin size = 1; store = 1'b1; end
      `LSU_OPCODE_SH:  begin size = 2; store = 1'b1; end
      `LSU_OPCODE_SW:  begin size = 4; store = 1'b1; end
      default:         legal = 1'b0;
    endcase
  endfunction

  // One complete transaction with gd stall cycles before grant and rd before rvalid.
  task automatic do_txn(input logic [3:0] op, input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] rd_word, input int gd, input int rd);
    int size, lane;
    bit legal, store, sgn;
    logic [1:0] ecode;
    logic [3:0] ebe;
    logic [31:0] ewd, eres;
    longint v;
    ref_decode(op, size, legal, store, sgn);
    lane  = int'(a % 4);
    ecode = !legal ? 2'b11 : ((a % size) != 0) ? 2'b01 : 2'b00;
    ebe   = 4'(((1 << size) - 1) << lane);
    ewd   = 32'h0;
    if (store) for (int k = 0; k < 4; k++) ewd[8*k +: 8] = wd[8*(k % size) +: 8];
    v = (longint'(rd_word) >> (8*lane)) & ((longint'(1) << (8*size)) - 1);
    if (sgn && v >= (longint'(1) << (8*size - 1))) v = v - (longint'(1) << (8*size));
    eres = store ? 32'h0 : v[31:0];

    @(negedge clk);
    chk("ready_idle", ready, 1'b1);
    valid = 1'b1; opc = op; addr = a; wdata = wd;
    @(posedge clk);
    #1 valid = 1'b0; opc = 4'($urandom); addr = $urandom; wdata = $urandom;
    @(negedge clk);
    if (ecode != 2'b00) begin
      chk("err_pulse", err, 1'b1);
      chk("err_code", code, ecode);
      chk("err_no_req", req, 1'b0);
      chk("err_ready", ready, 1'b0);
      chk("err_rdata_hold", rdata_o, exp_rdata);
      @(negedge clk);
      chk("err_clear", err, 1'b0);
      chk("err_ready_back", ready, 1'b1);
    end else begin
      for (int i = 0; i <= gd; i++) begin
        if (i > 0) @(negedge clk);
        chk("req", req, 1'b1);
        chk("we", we, store);
        chk("be", be, ebe);
        chk("maddr", maddr, {a[31:2], 2'b00});
        chk("mwdata", mwdata, ewd);
        chk("req_no_done", done, 1'b0);
        chk("req_ready", ready, 1'b0);
        gnt    = (i == gd);
        rvalid = (i == gd) && (rd > 0);
        mrdata = ~rd_word;
      end
      for (int j = 0; j <= rd; j++) begin
        @(negedge clk);
        gnt = 1'b0;
        chk("wait_req_low", req, 1'b0);
        chk("wait_be_zero", be, 4'b0000);
        chk("wait_wd_zero", mwdata, 32'h0);
        chk("wait_no_done", done, 1'b0);
        rvalid = (j == rd);
        mrdata = (j == rd) ? rd_word : ~rd_word;
      end
      @(negedge clk);
      rvalid = 1'b0; mrdata = $urandom;
      chk("done_pulse", done, 1'b1);
      chk("done_rdata", rdata_o, eres);
      chk("done_no_err", err, 1'b0);
      exp_rdata = eres;
      @(negedge clk);
      chk("done_clear", done, 1'b0);
      chk("ready_back", ready, 1'b1);
      chk("rdata_hold", rdata_o, exp_rdata);
    end
  endtask

  initial begin
    rst = 1'b1; valid = 1'b0; opc = 4'h0; addr = 32'h0; wdata = 32'h0;
    gnt = 1'b0; rvalid = 1'b0; mrdata = 32'h0;
    valid2 = 1'b0; opc2 = 4'h0; addr2 = 32'h0; wdata2 = 32'h0;
    gnt2 = 1'b0; rvalid2 = 1'b0; mrdata2 = 32'h0;
    #2;
    chk("rst_ready", ready, 1'b1);
    chk("rst_req", req, 1'b0);
    chk("rst_be", be, 4'b0000);
    chk("rst_rdata", rdata_o, 32'h0);
    chk("rst_ready2", ready2, 1'b1);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;

    do_txn(`LSU_OPCODE_LW, 32'h100, 32'h0, 32'hDEADBEEF, 0, 0);
    chk("lw_result", rdata_o, 32'hDEADBEEF);
    do_txn(`LSU_OPCODE_LB, 32'h203, 32'h0, 32'h80FF1234, 0, 0);
    chk("lb_result", rdata_o, 32'hFFFFFF80);
    do_txn(`LSU_OPCODE_LBU, 32'h203, 32'h0, 32'h80FF1234, 1, 0);
    chk("lbu_result", rdata_o, 32'h00000080);
    do_txn(`LSU_OPCODE_SH, 32'h302, 32'h0000ABCD, 32'h0, 3, 1);
    do_txn(`LSU_OPCODE_LW, 32'h101, 32'h0, 32'h0, 0, 0);
    do_txn(`LSU_OPCODE_LH, 32'h103, 32'h0, 32'h0, 0, 0);
    do_txn(4'hF, 32'h0, 32'h0, 32'h0, 0, 0);
    do_txn(`LSU_OPCODE_SB, 32'h001, 32'h0000005A, 32'h0, 1, 0);
    do_txn(`LSU_OPCODE_SW, 32'h404, 32'h12345678, 32'h0, 0, 2);
    do_txn(`LSU_OPCODE_LH, 32'h006, 32'h0, 32'h9ABC1234, 0, 0);
    chk("lh_upper", rdata_o, 32'hFFFF9ABC);

    // Timeout instance: no grant ever arrives.
    @(negedge clk);
    valid2 = 1'b1; opc2 = `LSU_OPCODE_LW; addr2 = 32'h40;
    @(posedge clk);
    #1 valid2 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("to_req_held", req2, 1'b1);
      chk("to_no_err_yet", err2, 1'b0);
    end
    @(negedge clk);
    chk("to_err", err2, 1'b1);
    chk("to_code", code2, 2'b10);
    chk("to_req_drop", req2, 1'b0);
    rvalid2 = 1'b1; mrdata2 = 32'hFFFFFFFF;
    @(negedge clk);
    chk("to_err_clear", err2, 1'b0);
    chk("to_ready_back", ready2, 1'b1);
    chk("to_late_no_done", done2, 1'b0);
    @(negedge clk);
    chk("to_late_no_done2", done2, 1'b0);
    rvalid2 = 1'b0;

    // Asynchronous reset while waiting for a response.
    do_txn(`LSU_OPCODE_LW, 32'h10, 32'h0, 32'hCAFE0001, 0, 0);
    @(negedge clk);
    valid = 1'b1; opc = `LSU_OPCODE_LW; addr = 32'h20;
    @(posedge clk);
    #1 valid = 1'b0;
    @(negedge clk);
    gnt = 1'b1;
    @(posedge clk);
    #1 gnt = 1'b0;
    @(negedge clk);
    chk("pre_rst_ready", ready, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk("arst_ready", ready, 1'b1);
    chk("arst_req", req, 1'b0);
    chk("arst_we", we, 1'b0);
    chk("arst_be", be, 4'b0000);
    chk("arst_maddr", maddr, 32'h0);
    chk("arst_mwdata", mwdata, 32'h0);
    chk("arst_done", done, 1'b0);
    chk("arst_err", err, 1'b0);
    chk("arst_code", code, 2'b00);
    chk("arst_rdata", rdata_o, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    exp_rdata = 32'h0;
    do_txn(`LSU_OPCODE_LHU, 32'h002, 32'h0, 32'h80010000, 0, 0);
    chk("lhu_after_rst", rdata_o, 32'h00008001);

    for (int n = 0; n < 40; n++) begin
      rop = 4'($urandom_range(0, 15));
      do_txn(rop, $urandom, $urandom, $urandom, $urandom_range(0, 3), $urandom_range(0, 3));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
